uart_rx: RTL
============

// Module: uart_rx
// PURPOSE
//   8N1 UART receiver; mirror of the existing transmitter on the host serial link.
//   Synchronises the async rx line and validates the start bit at mid-bit.
//   Samples 8 data bits LSB-first plus the stop bit, then presents the byte to the
//   matrix-engine command path over a valid/ready handshake.
//   Reports framing errors and overruns as 1-cycle pulses.
// PARAMETERS
//   CLKS_PER_BIT  435  clk cycles per bit (matches tx divider: 434 wrap = 435 cycles); min 4
//   HALF_BIT      CLKS_PER_BIT/2  derived (localparam, integer division), mid-bit offset
// PORTS
//   clk         in   1  system clock, all logic on posedge
//   rst         in   1  asynchronous, active-high reset
//   rx          in   1  serial line, idle high, asynchronous to clk
//   data_out    out  8  received byte, stable while data_valid=1
//   data_valid  out  1  byte available; held until accepted
//   data_ready  in   1  consumer accepts byte when data_valid & data_ready on a clk edge
//   frame_err   out  1  1-cycle pulse: stop bit sampled 0
//   overrun     out  1  1-cycle pulse: new byte arrived while previous unaccepted
//   busy        out  1  1 in any state other than IDLE
// BEHAVIOUR
//   Reset: data_out=0, data_valid=0, frame_err=0, overrun=0, busy=0, state=IDLE;
//     both sync flops=1, bit counter and clk counter=0. Reset mid-frame aborts the frame.
//   rx_s = rx through 2 flops (2-cycle lag); FSM uses only rx_s.
//   States: IDLE, START, DATA, STOP, BREAK.
//   T0 = first edge where state=IDLE and rx_s=0.
//   IDLE  -> START at T0; clk counter cleared.
//   START: at T0+HALF_BIT check rx_s: 0 -> DATA; 1 -> IDLE (glitch, no outputs).
//   DATA:  bit i (i=0..7) sampled at T0+HALF_BIT+(i+1)*CLKS_PER_BIT;
//          shifted in LSB-first; after bit 7 -> STOP.
//   STOP:  sampled at T0+HALF_BIT+9*CLKS_PER_BIT.
//     rx_s=1: next cycle data_out<=byte, data_valid<=1; state -> IDLE.
//       If data_valid was already 1 and not accepted that cycle: overrun pulses 1
//       cycle and data_out is overwritten (newest byte wins).
//     rx_s=0: frame_err pulses 1 cycle, byte discarded, data_valid unchanged;
//       state -> BREAK.
//   BREAK: wait until rx_s=1, then IDLE (no start detection while line held low).
//   Returning to IDLE at mid-stop lets the next start edge be caught in the
//     second half of the stop bit; back-to-back frames must not be lost.
//   Handshake: data_valid & data_ready on an edge clears data_valid next cycle,
//     unless a new byte loads on that same edge: then data_valid stays 1,
//     data_out takes the new byte, and overrun does not pulse.
//   data_ready while data_valid=0 is ignored.
//   Counter width: $clog2(CLKS_PER_BIT)+1 bits; it never exceeds CLKS_PER_BIT-1.
// TESTING (bench uses CLKS_PER_BIT=16; drive rx at 16 clk/bit)
//   1. Frame 0xA5, stop=1, data_ready=0 -> data_valid=1 at T0+HALF_BIT+9*16+1,
//      data_out=0xA5, held; data_ready=1 one cycle -> data_valid=0 next cycle.
//   2. rx low for 3 cycles only -> START aborts to IDLE; no data_valid, no frame_err,
//      busy back to 0.
//   3. Frame 0x3C with stop=0, then rx low 40 cycles, then high, then frame 0x55
//      -> single frame_err pulse; stays BREAK while low; then data_out=0x55, valid=1.
//   4. Frames 0x11 then 0x22 back-to-back, data_ready=0 -> overrun pulse on 2nd load;
//      data_out=0x22, data_valid=1.
//   5. rst asserted during data bit 4 of 0xC3 -> all outputs 0 immediately;
//      after release, frame 0x0F -> data_out=0x0F, no frame_err.
//   6. data_ready tied 1, frames 0x00 then 0xFF with 1-bit stop -> two 1-cycle
//      data_valid pulses carrying 0x00, 0xFF; no overrun.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop rx synchroniser, mid-bit sampling, and a valid/ready
// byte output with single-cycle frame-error and overrun pulses.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 435
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_valid,
    input  logic       data_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int unsigned HALF_BIT = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_e;

    state_e           state_q;
    logic             rx_meta_q;
    logic             rx_s_q;
    logic [CNT_W-1:0] clk_cnt_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_out_q;
    logic             data_valid_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             busy_q;

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;
    assign busy       = busy_q;

    // Two-flop synchroniser; line idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            // Consumer handshake; a byte loading on the same edge overrides this below.
            if (data_valid_q && data_ready) begin
                data_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q   <= START;
                        clk_cnt_q <= '0;
                        busy_q    <= 1'b1;
                    end
                end
                START: begin
                    if (clk_cnt_q == HALF_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s_q) begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        shift_q   <= {rx_s_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (clk_cnt_q == BIT_LAST) begin
                        clk_cnt_q <= '0;
                        if (rx_s_q) begin
                            // Leave at mid-stop so a back-to-back start edge is not missed.
                            data_out_q   <= shift_q;
                            data_valid_q <= 1'b1;
                            overrun_q    <= data_valid_q && !data_ready;
                            state_q      <= IDLE;
                            busy_q       <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= BREAK;
                        end
                    end else begin
                        clk_cnt_q <= clk_cnt_q + CNT_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
